// File: rtl/instruction_fetch.sv
// Instruction fetch stage: drives the instruction memory request and fills the IF/ID register.
// It handles decode stalls with a one-entry hold buffer and squashes fetches that were in flight when a branch was taken.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pc_load,
  input  logic        if_id_load,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] pc,
  output logic        valid,
  output logic [1:0]  state
);

  localparam logic [1:0] REQ     = 2'b00;
  localparam logic [1:0] HOLD    = 2'b01;
  localparam logic [1:0] DISCARD = 2'b10;

  // Handshake: a word is transferred in any cycle where imem_req and imem_ack are both high.
  // imem_addr stays stable from the cycle a request is raised until that transfer happens.

  logic [31:0] pc_reg;
  logic [31:0] pc_next_seq;
  logic [31:0] hold_data;
  logic [31:0] hold_pc;
  logic [31:0] discard_addr;
  logic        advance;

  assign advance     = pc_load & if_id_load;
  assign pc_next_seq = pc_reg + 32'd4;

  // A squashed request stays on its original address until the memory answers it.
  assign imem_req  = ~reset & (state != HOLD);
  assign imem_addr = (state == DISCARD) ? discard_addr : pc_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= REQ;
      pc_reg       <= RESET_PC;
      instruction  <= NOP;
      pc           <= 32'h0000_0000;
      valid        <= 1'b0;
      hold_data    <= 32'h0000_0000;
      hold_pc      <= 32'h0000_0000;
      discard_addr <= 32'h0000_0000;
    end else if (branch_taken) begin
      pc_reg      <= {branch_target[31:2], 2'b00};
      instruction <= NOP;
      valid       <= 1'b0;
      hold_data   <= 32'h0000_0000;
      hold_pc     <= 32'h0000_0000;
      case (state)
        REQ: begin
          if (imem_ack) begin
            state <= REQ;
          end else begin
            state        <= DISCARD;
            discard_addr <= pc_reg;
          end
        end
        HOLD:    state <= REQ;
        DISCARD: state <= imem_ack ? REQ : DISCARD;
        default: state <= REQ;
      endcase
    end else begin
      case (state)
        REQ: begin
          if (imem_ack) begin
            if (advance) begin
              instruction <= imem_rdata;
              pc          <= pc_reg;
              valid       <= 1'b1;
              pc_reg      <= pc_next_seq;
            end else begin
              hold_data <= imem_rdata;
              hold_pc   <= pc_reg;
              state     <= HOLD;
            end
          end else if (if_id_load) begin
            instruction <= NOP;
            valid       <= 1'b0;
          end
        end
        HOLD: begin
          if (advance) begin
            instruction <= hold_data;
            pc          <= hold_pc;
            valid       <= 1'b1;
            pc_reg      <= pc_next_seq;
            state       <= REQ;
          end
        end
        DISCARD: begin
          instruction <= NOP;
          valid       <= 1'b0;
          if (imem_ack) state <= REQ;
        end
        default: state <= REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: a zero-wait memory model with a switchable ack,
// and hand-computed expectations for streaming, stall, branch and reset scenarios.
module tb_instruction_fetch;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [1:0]  S_REQ  = 2'b00;
  localparam logic [1:0]  S_HOLD = 2'b01;
  localparam logic [1:0]  S_DISC = 2'b10;

  logic        clock;
  logic        reset;
  logic        pc_load;
  logic        if_id_load;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic        valid;
  logic [1:0]  state;
  logic        ack_en;

  int checks;
  int failures;

  instruction_fetch dut (
    .clock(clock), .reset(reset), .pc_load(pc_load), .if_id_load(if_id_load),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .instruction(instruction), .pc(pc),
    .valid(valid), .state(state)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  assign imem_ack   = ack_en & imem_req;
  assign imem_rdata = mem_word(imem_addr);

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", tag, actual, expected);
    end
  endtask

  task automatic set_adv(input logic a);
    pc_load    = a;
    if_id_load = a;
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    reset         = 1'b1;
    ack_en        = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 32'h0;
    set_adv(1'b1);
    tick();
    tick();

    // Reset state
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_instr", instruction, NOP);
    check("rst_pc", pc, 32'd0);
    reset = 1'b0;
    #1;
    check("first_req", {31'd0, imem_req}, 32'd1);
    check("first_addr", imem_addr, 32'h0);

    // Back-to-back streaming
    ack_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("stream_pc", pc, 32'(i * 4));
      check("stream_valid", {31'd0, valid}, 32'd1);
      check("stream_instr", instruction, mem_word(32'(i * 4)));
    end
    check("stream_next_addr", imem_addr, 32'd16);

    // Stall with hold buffer at address 8
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    tick();
    check("pre_hold_addr", imem_addr, 32'd8);
    set_adv(1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_state", {30'd0, state}, {30'd0, S_HOLD});
      check("hold_req", {31'd0, imem_req}, 32'd0);
      check("hold_pc", pc, 32'd4);
      check("hold_instr", instruction, mem_word(32'd4));
    end
    set_adv(1'b1);
    tick();
    check("release_pc", pc, 32'd8);
    check("release_instr", instruction, mem_word(32'd8));
    check("release_valid", {31'd0, valid}, 32'd1);
    check("release_addr", imem_addr, 32'd12);

    // No ack with if_id_load: bubble inserted, pc field kept
    ack_en     = 1'b0;
    pc_load    = 1'b0;
    if_id_load = 1'b1;
    tick();
    check("bubble_valid", {31'd0, valid}, 32'd0);
    check("bubble_instr", instruction, NOP);
    check("bubble_pc", pc, 32'd8);
    check("bubble_addr", imem_addr, 32'd12);

    // Branch with ack at 0x20, target misaligned
    set_adv(1'b1);
    ack_en        = 1'b1;
    branch_taken  = 1'b1;
    branch_target = 32'h20;
    tick();
    check("br_to_20_addr", imem_addr, 32'h20);
    branch_target = 32'h103;
    tick();
    branch_taken = 1'b0;
    check("br_ack_valid", {31'd0, valid}, 32'd0);
    check("br_ack_instr", instruction, NOP);
    check("br_ack_addr", imem_addr, 32'h100);
    tick();
    check("br_tgt_pc", pc, 32'h100);
    check("br_tgt_instr", instruction, mem_word(32'h100));
    check("br_tgt_valid", {31'd0, valid}, 32'd1);

    // Branch while request at 0x40 is outstanding
    branch_taken  = 1'b1;
    branch_target = 32'h40;
    tick();
    check("to_40_addr", imem_addr, 32'h40);
    ack_en        = 1'b0;
    branch_target = 32'h200;
    tick();
    branch_taken = 1'b0;
    check("disc_state", {30'd0, state}, {30'd0, S_DISC});
    check("disc_addr0", imem_addr, 32'h40);
    check("disc_req0", {31'd0, imem_req}, 32'd1);
    check("disc_valid0", {31'd0, valid}, 32'd0);
    tick();
    check("disc_addr1", imem_addr, 32'h40);
    check("disc_valid1", {31'd0, valid}, 32'd0);
    ack_en = 1'b1;
    tick();
    check("disc_done_state", {30'd0, state}, {30'd0, S_REQ});
    check("disc_done_addr", imem_addr, 32'h200);
    check("disc_done_valid", {31'd0, valid}, 32'd0);
    tick();
    check("after_disc_pc", pc, 32'h200);
    check("after_disc_instr", instruction, mem_word(32'h200));
    check("after_disc_valid", {31'd0, valid}, 32'd1);

    // Address wrap
    branch_taken  = 1'b1;
    branch_target = 32'hFFFF_FFFC;
    tick();
    branch_taken = 1'b0;
    check("wrap_pre_addr", imem_addr, 32'hFFFF_FFFC);
    tick();
    check("wrap_pc", pc, 32'hFFFF_FFFC);
    check("wrap_addr", imem_addr, 32'h0);

    // Reset while holding
    set_adv(1'b0);
    tick();
    check("pre_rst_hold", {30'd0, state}, {30'd0, S_HOLD});
    check("pre_rst_valid", {31'd0, valid}, 32'd1);
    reset = 1'b1;
    #1;
    check("rst_hold_valid", {31'd0, valid}, 32'd0);
    check("rst_hold_instr", instruction, NOP);
    check("rst_hold_req", {31'd0, imem_req}, 32'd0);
    check("rst_hold_state", {30'd0, state}, {30'd0, S_REQ});
    tick();
    reset = 1'b0;
    #1;
    check("post_rst_addr", imem_addr, 32'h0);
    check("post_rst_req", {31'd0, imem_req}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
